// File: rtl/mult_div_unit_pkg.sv
// Shared MDU opcode and FSM state encodings, plus op-class decode helpers.
// MDU_MADD_EN adds the multiply-accumulate opcodes to the multiply class.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_mult_op(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// HILO handshake between the E stage (master) and the multiply/divide unit (slave).
// busy feeds the D-stage stall logic; md_out is the MFHI/MFLO read path.
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output start, mdu_op, rs_data, rt_data,
    input  busy, hi, lo, md_out
  );

  modport slave (
    input  start, mdu_op, rs_data, rt_data,
    output busy, hi, lo, md_out
  );
endinterface

// File: rtl/mult_div_unit_calc.sv
// Combinational HI/LO result for the op at the start edge, plus a divide-by-zero flag.
// Zero latency; no handshake (MDU_MADD_EN enables the accumulate forms).
module mult_div_unit_calc
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] q_u;
  logic [31:0] r_u;

  // Sign-extending to 64 bits makes the low half of the product the signed result.
  assign prod_u = {32'd0, rs} * {32'd0, rt};
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};

  // Signed divide runs on magnitudes so the most-negative dividend needs no special case.
  assign signed_div = (op == MDU_DIV);
  assign rs_neg     = signed_div & rs[31];
  assign rt_neg     = signed_div & rt[31];
  assign num        = rs_neg ? (~rs + 32'd1) : rs;
  assign den        = (rt == 32'd0) ? 32'd1 : (rt_neg ? (~rt + 32'd1) : rt);
  assign q_u        = num / den;
  assign r_u        = num % den;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo};
`endif

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    div0   = 1'b0;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        div0   = (rt == 32'd0);
        res_lo = (rs_neg ^ rt_neg) ? (~q_u + 32'd1) : q_u;
        res_hi = rs_neg ? (~r_u + 32'd1) : r_u;
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {res_hi, res_lo} = acc + prod_s;
      MDU_MADDU: {res_hi, res_lo} = acc + prod_u;
      MDU_MSUB:  {res_hi, res_lo} = acc - prod_s;
      MDU_MSUBU: {res_hi, res_lo} = acc - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: start pulse -> busy for MULT_LAT/DIV_LAT cycles -> HI/LO commit.
// start/MTHI/MTLO are ignored while busy; md_out is a zero-latency MFHI/MFLO mux (MDU_MADD_EN adds MADD-class ops).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  mdu
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  mdu_state_e  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] hi, hi_nxt;
  logic [31:0] lo, lo_nxt;
  logic [31:0] hi_tmp, hi_tmp_nxt;
  logic [31:0] lo_tmp, lo_tmp_nxt;
  logic        div0_tmp, div0_tmp_nxt;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_div0;

  mult_div_unit_calc u_calc (
    .op     (mdu.mdu_op),
    .rs     (mdu.rs_data),
    .rt     (mdu.rt_data),
    .hi     (hi),
    .lo     (lo),
    .res_hi (calc_hi),
    .res_lo (calc_lo),
    .div0   (calc_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MDU_IDLE;
      cnt      <= 4'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      hi_tmp   <= 32'd0;
      lo_tmp   <= 32'd0;
      div0_tmp <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      hi_tmp   <= hi_tmp_nxt;
      lo_tmp   <= lo_tmp_nxt;
      div0_tmp <= div0_tmp_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hi_nxt       = hi;
    lo_nxt       = lo;
    hi_tmp_nxt   = hi_tmp;
    lo_tmp_nxt   = lo_tmp;
    div0_tmp_nxt = div0_tmp;
    case (state)
      MDU_IDLE: begin
        if (mdu.start && (is_mult_op(mdu.mdu_op) || is_div_op(mdu.mdu_op))) begin
          cnt_nxt      = is_div_op(mdu.mdu_op) ? DIV_CNT : MULT_CNT;
          hi_tmp_nxt   = calc_hi;
          lo_tmp_nxt   = calc_lo;
          div0_tmp_nxt = calc_div0;
          state_nxt    = MDU_BUSY;
        end else if (!mdu.start) begin
          if (mdu.mdu_op == MDU_MTHI) hi_nxt = mdu.rs_data;
          if (mdu.mdu_op == MDU_MTLO) lo_nxt = mdu.rs_data;
        end
      end
      MDU_BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          // Divide by zero still occupies the unit but leaves HI/LO untouched.
          if (!div0_tmp) begin
            hi_nxt = hi_tmp;
            lo_nxt = lo_tmp;
          end
          state_nxt = MDU_IDLE;
        end
      end
      default: state_nxt = MDU_IDLE;
    endcase
  end

  assign mdu.busy = (state == MDU_BUSY);
  assign mdu.hi   = hi;
  assign mdu.lo   = lo;

  always_comb begin
    mdu.md_out = 32'd0;
    if (mdu.mdu_op == MDU_MFHI) mdu.md_out = hi;
    if (mdu.mdu_op == MDU_MFLO) mdu.md_out = lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: timeline model of HI/LO plus literal checkpoints.
// Build with MDU_MADD_EN defined to exercise the accumulate path.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if mdu_if ();

  mult_div_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu_if)
  );

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op schedules its result for edge start+LAT; the unit is busy until then.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          pend = 1'b0, p_keep = 1'b0;
  int          edge_no = 0, commit_at = 0, lat;
  int          sa, sb;
  longint      ps;
  longint unsigned ua, ub, pu;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; pend = 1'b0;
    end else begin
      edge_no++;
      if (pend) begin
        if (edge_no == commit_at) begin
          if (!p_keep) begin m_hi = p_hi; m_lo = p_lo; end
          pend = 1'b0;
        end
      end else if (mdu_if.start) begin
        sa = mdu_if.rs_data; sb = mdu_if.rt_data;
        ua = mdu_if.rs_data; ub = mdu_if.rt_data;
        ps = longint'(sa) * longint'(sb);
        pu = ua * ub;
        lat = 0; p_keep = 1'b0;
        case (mdu_if.mdu_op)
          MDU_MULT:  begin {p_hi, p_lo} = ps; lat = MULT_LAT; end
          MDU_MULTU: begin {p_hi, p_lo} = pu; lat = MULT_LAT; end
          MDU_DIV: begin
            lat = DIV_LAT; p_keep = (sb == 0);
            if (sb != 0) begin p_lo = sa / sb; p_hi = sa % sb; end
          end
          MDU_DIVU: begin
            lat = DIV_LAT; p_keep = (ub == 0);
            if (ub != 0) begin p_lo = 32'(ua / ub); p_hi = 32'(ua % ub); end
          end
`ifdef MDU_MADD_EN
          MDU_MADD:  begin {p_hi, p_lo} = {m_hi, m_lo} + ps; lat = MULT_LAT; end
          MDU_MADDU: begin {p_hi, p_lo} = {m_hi, m_lo} + pu; lat = MULT_LAT; end
          MDU_MSUB:  begin {p_hi, p_lo} = {m_hi, m_lo} - ps; lat = MULT_LAT; end
          MDU_MSUBU: begin {p_hi, p_lo} = {m_hi, m_lo} - pu; lat = MULT_LAT; end
`endif
          default: ;
        endcase
        if (lat > 0) begin pend = 1'b1; commit_at = edge_no + lat; end
      end else if (mdu_if.mdu_op == MDU_MTHI) begin
        m_hi = mdu_if.rs_data;
      end else if (mdu_if.mdu_op == MDU_MTLO) begin
        m_lo = mdu_if.rs_data;
      end
    end
  end

  always @(negedge clk) begin
    if (run && !reset) begin
      chk("cyc_busy", {31'd0, mdu_if.busy}, {31'd0, pend});
      chk("cyc_hi", mdu_if.hi, m_hi);
      chk("cyc_lo", mdu_if.lo, m_lo);
      chk("cyc_md_out", mdu_if.md_out,
          (mdu_if.mdu_op == MDU_MFHI) ? m_hi : (mdu_if.mdu_op == MDU_MFLO) ? m_lo : 32'd0);
    end
  end

  task automatic set_in(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic st);
    mdu_if.mdu_op  = op;
    mdu_if.rs_data = rs;
    mdu_if.rt_data = rt;
    mdu_if.start   = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    set_in(op, rs, rt, 1'b1);
    step();
    set_in(MDU_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (mdu_if.busy && n < 40) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    set_in(MDU_NONE, 32'd0, 32'd0, 1'b0);
    step();
    step();
    chk("rst_busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("rst_hi", mdu_if.hi, 32'd0);
    chk("rst_lo", mdu_if.lo, 32'd0);
    chk("rst_md_out", mdu_if.md_out, 32'd0);
    reset = 1'b0;
    run   = 1'b1;
    step();

    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy_after_start", {31'd0, mdu_if.busy}, 32'd1);
    wait_idle(n);
    chk("mult_lat", n, 32'd5);
    chk("mult_hi", mdu_if.hi, 32'hFFFF_FFFF);
    chk("mult_lo", mdu_if.lo, 32'hFFFF_FFF1);

    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lat", n, 32'd10);
    chk("divu_lo", mdu_if.lo, 32'd3);
    chk("divu_hi", mdu_if.hi, 32'd1);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_lo", mdu_if.lo, 32'hFFFF_FFFD);
    chk("div_hi", mdu_if.hi, 32'hFFFF_FFFF);

    set_in(MDU_MTLO, 32'd1234, 32'd0, 1'b0);
    step();
    set_in(MDU_NONE, 32'd0, 32'd0, 1'b0);
    chk("mtlo_lo", mdu_if.lo, 32'd1234);
    issue(MDU_DIV, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_lat", n, 32'd10);
    chk("div0_lo_kept", mdu_if.lo, 32'd1234);
    chk("div0_hi_kept", mdu_if.hi, 32'hFFFF_FFFF);

    issue(MDU_MULTU, 32'd2, 32'd3);
    set_in(MDU_MULT, 32'd9, 32'd9, 1'b1);
    step();
    set_in(MDU_MTHI, 32'h5555_5555, 32'd0, 1'b0);
    step();
    set_in(MDU_NONE, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    chk("multu_overlap_lat", n, 32'd3);
    chk("multu_lo", mdu_if.lo, 32'd6);
    chk("multu_hi", mdu_if.hi, 32'd0);
    step();
    step();
    chk("multu_no_second", {31'd0, mdu_if.busy}, 32'd0);

    set_in(MDU_MTHI, 32'hABCD_0000, 32'd0, 1'b0);
    step();
    set_in(MDU_MFHI, 32'd0, 32'd0, 1'b0);
    #1 chk("mfhi", mdu_if.md_out, 32'hABCD_0000);
    set_in(MDU_MFLO, 32'd0, 32'd0, 1'b0);
    #1 chk("mflo", mdu_if.md_out, 32'd6);
    set_in(MDU_NONE, 32'd0, 32'd0, 1'b0);
    #1 chk("md_out_none", mdu_if.md_out, 32'd0);

    issue(4'hF, 32'd1, 32'd1);
    chk("unknown_op_busy", {31'd0, mdu_if.busy}, 32'd0);

    set_in(MDU_MTHI, 32'd0, 32'd0, 1'b0);
    step();
    set_in(MDU_MTLO, 32'd10, 32'd0, 1'b0);
    step();
    issue(MDU_MADD, 32'd2, 32'd3);
    wait_idle(n);
`ifdef MDU_MADD_EN
    chk("madd_lat", n, 32'd5);
    chk("madd_lo", mdu_if.lo, 32'd16);
    chk("madd_hi", mdu_if.hi, 32'd0);
`else
    chk("madd_off_lat", n, 32'd0);
    chk("madd_off_lo", mdu_if.lo, 32'd10);
    chk("madd_off_hi", mdu_if.hi, 32'd0);
`endif

    issue(MDU_MULT, 32'd7, 32'd7);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("rst_mid_hi", mdu_if.hi, 32'd0);
    chk("rst_mid_lo", mdu_if.lo, 32'd0);
    step();
    reset = 1'b0;
    repeat (8) step();
    chk("rst_no_commit_lo", mdu_if.lo, 32'd0);
    chk("rst_no_commit_busy", {31'd0, mdu_if.busy}, 32'd0);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
